dec_scan_n: RTL and testbench

//  Parametrised active-low N-to-2^N decoder, successor to the dual 2-to-4 decoder.

---
 rtl/dec_scan_pkg.sv | 28 ++
 rtl/dec_scan_timer.sv | 27 ++
 rtl/dec_scan_n.sv | 119 +++++++++++
 tb/tb_dec_scan_n.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the dec_scan_n strobe decoder.
// Contents: FSM state enum, default/maximum widths, active-low one-hot helper.
// No ports; imported by dec_scan_timer and dec_scan_n.
package dec_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int DEF_SEL_W = 2;
  localparam int DEF_OUT_W = 1 << DEF_SEL_W;
  // Upper bound on decoder width the helper can build (SEL_W up to 8).
  localparam int MAX_OUT_W = 256;

  // Active-low one-hot: bits [w-1:0] are 1 except bit idx; bits above w are 0.
  // Callers slice the low OUT_W bits.
  function automatic logic [MAX_OUT_W-1:0] onehot_low(input int idx, input int w);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_OUT_W; i++) begin
      if (i < w) r[i] = (i != idx);
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_scan_timer.sv
// Loadable down-counter used for both the dwell and the blanking gap.
// Latency: load value visible the cycle after load; saturates at zero.
// Ports: clk, rst_n (async low), load, load_val -> cnt, zero (cnt == 0).
module dec_scan_timer import dec_scan_pkg::*; #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dec_scan_n.sv
// Active-low N-to-2^N strobe decoder with DIRECT decode and auto-SCAN modes.
// Latency 1: every output is registered and reflects the inputs of the prior edge.
// Ports: CLK, RESET_L, G_L, MODE, SEL, SCAN_LAST -> Y_L, IDX, WRAP.
module dec_scan_n import dec_scan_pkg::*; #(
  parameter int SEL_W = DEF_SEL_W,
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_L,
  input  logic                  G_L,
  input  logic                  MODE,
  input  logic [SEL_W-1:0]      SEL,
  input  logic [SEL_W-1:0]      SCAN_LAST,
  output logic [(1<<SEL_W)-1:0] Y_L,
  output logic [SEL_W-1:0]      IDX,
  output logic                  WRAP
);

  localparam int OUT_W   = 1 << SEL_W;
  localparam int CNT_MAX = (DWELL > GAP) ? ((DWELL > 2) ? DWELL : 2)
                                         : ((GAP > 2) ? GAP : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam logic [OUT_W-1:0] ALL_HI   = '1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_d, adv_idx;
  logic [OUT_W-1:0]   y_d;
  logic               wrap_d, adv_wrap;
  logic               tmr_load, tmr_zero;
  logic [CNT_W-1:0]   tmr_val, tmr_cnt;

  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] i);
    logic [MAX_OUT_W-1:0] t;
    t = onehot_low(int'(i), OUT_W);
    return t[OUT_W-1:0];
  endfunction

  dec_scan_timer #(.W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RESET_L),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_comb begin
    // SCAN_LAST is only consulted here, so a mid-dwell change lands at the next step;
    // '>=' makes an index already past a lowered SCAN_LAST wrap immediately.
    adv_wrap = (IDX >= SCAN_LAST);
    adv_idx  = adv_wrap ? '0 : IDX + SEL_W'(1);

    state_d  = state_q;
    idx_d    = IDX;
    y_d      = ALL_HI;
    wrap_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = DWELL_LD;

    if (G_L) begin
      state_d = IDLE;
    end else if (!MODE) begin
      state_d = IDLE;
      idx_d   = SEL;
      y_d     = dec(SEL);
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = DRIVE;
          idx_d    = '0;
          y_d      = dec('0);
          tmr_load = 1'b1;
        end
        DRIVE: begin
          if (!tmr_zero) begin
            y_d = dec(IDX);
          end else if (GAP > 0) begin
            state_d  = BLANK;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end else begin
            idx_d    = adv_idx;
            y_d      = dec(adv_idx);
            wrap_d   = adv_wrap;
            tmr_load = 1'b1;
          end
        end
        BLANK: begin
          if (tmr_zero) begin
            state_d  = DRIVE;
            idx_d    = adv_idx;
            y_d      = dec(adv_idx);
            wrap_d   = adv_wrap;
            tmr_load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= IDLE;
      IDX     <= '0;
      Y_L     <= ALL_HI;
      WRAP    <= 1'b0;
    end else begin
      state_q <= state_d;
      IDX     <= idx_d;
      Y_L     <= y_d;
      WRAP    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_dec_scan_n.sv
// Testbench for dec_scan_n: table of {inputs, expected outputs} with a scoreboard queue.
// Instance A: SEL_W=2 DWELL=3 GAP=1; instance B: DWELL=1 GAP=0.
// Expected values are written by hand from the intended strobe sequences.
module tb_dec_scan_n;

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic       g_l, mode;
  logic [1:0] sel, scan_last;
  logic [3:0] y_a, y_b;
  logic [1:0] idx_a, idx_b;
  logic       wrap_a, wrap_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  dec_scan_n #(.SEL_W(2), .DWELL(3), .GAP(1)) u_a (
    .CLK(CLK), .RESET_L(RESET_L), .G_L(g_l), .MODE(mode), .SEL(sel),
    .SCAN_LAST(scan_last), .Y_L(y_a), .IDX(idx_a), .WRAP(wrap_a)
  );

  dec_scan_n #(.SEL_W(2), .DWELL(1), .GAP(0)) u_b (
    .CLK(CLK), .RESET_L(RESET_L), .G_L(g_l), .MODE(mode), .SEL(sel),
    .SCAN_LAST(scan_last), .Y_L(y_b), .IDX(idx_b), .WRAP(wrap_b)
  );

  typedef struct {
    int         tst;
    bit         dut_b;
    logic       g;
    logic       m;
    logic [1:0] s;
    logic [1:0] sl;
    logic [3:0] y;
    logic [1:0] i;
    logic       w;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];
  int   vnum = 0;

  function automatic vec_t mk(int tst, bit b, logic g, logic m, logic [1:0] s,
                              logic [1:0] sl, logic [3:0] y, logic [1:0] i, logic w);
    vec_t v;
    v.tst = tst; v.dut_b = b; v.g = g; v.m = m; v.s = s; v.sl = sl;
    v.y = y; v.i = i; v.w = w;
    return v;
  endfunction

  task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got Y_L=%b IDX=%0d WRAP=%b, want Y_L=%b IDX=%0d WRAP=%b",
                  nm, got[6:3], got[2:1], got[0], exp[6:3], exp[2:1], exp[0]);
  endtask

  // Drive one vector, queue its expectation, compare after the next edge.
  task automatic apply(input vec_t v);
    vec_t e;
    logic [6:0] got;
    g_l = v.g; mode = v.m; sel = v.s; scan_last = v.sl;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    e   = sb.pop_front();
    got = e.dut_b ? {y_b, idx_b, wrap_b} : {y_a, idx_a, wrap_a};
    check($sformatf("vec%0d_t%0d%s", vnum, e.tst, e.dut_b ? "b" : "a"), got, {e.y, e.i, e.w});
    vnum++;
  endtask

  task automatic run_table();
    foreach (vt[k]) apply(vt[k]);
    vt.delete();
  endtask

  initial begin
    logic [3:0] oh;
    RESET_L = 1'b0; g_l = 1'b0; mode = 1'b0; sel = 2'd2; scan_last = 2'd3;

    // 1. reset state while held
    repeat (2) @(posedge CLK);
    #1;
    check("reset_a", {y_a, idx_a, wrap_a}, {4'b1111, 2'd0, 1'b0});
    check("reset_b", {y_b, idx_b, wrap_b}, {4'b1111, 2'd0, 1'b0});
    RESET_L = 1'b1;

    vt.push_back(mk(1, 0, 0, 0, 2, 3, 4'b1011, 2, 0));
    // 2. direct sweep, then disable
    vt.push_back(mk(2, 0, 0, 0, 0, 3, 4'b1110, 0, 0));
    vt.push_back(mk(2, 0, 0, 0, 1, 3, 4'b1101, 1, 0));
    vt.push_back(mk(2, 0, 0, 0, 2, 3, 4'b1011, 2, 0));
    vt.push_back(mk(2, 0, 0, 0, 3, 3, 4'b0111, 3, 0));
    vt.push_back(mk(2, 0, 1, 0, 3, 3, 4'b1111, 3, 0));
    // 3. full frame, SCAN_LAST=3
    for (int i = 0; i < 4; i++) begin
      oh = 4'b1111;
      oh[i] = 1'b0;
      for (int d = 0; d < 3; d++) vt.push_back(mk(3, 0, 0, 1, 0, 3, oh, 2'(i), 0));
      vt.push_back(mk(3, 0, 0, 1, 0, 3, 4'b1111, 2'(i), 0));
    end
    vt.push_back(mk(3, 0, 0, 1, 0, 3, 4'b1110, 0, 1));
    vt.push_back(mk(3, 0, 0, 1, 0, 3, 4'b1110, 0, 0));
    vt.push_back(mk(3, 0, 0, 1, 0, 3, 4'b1110, 0, 0));
    vt.push_back(mk(3, 0, 0, 1, 0, 3, 4'b1111, 0, 0));
    // 4. SCAN_LAST lowered to 1 while IDX=2, then SCAN_LAST=0
    for (int d = 0; d < 3; d++) vt.push_back(mk(4, 0, 0, 1, 0, 3, 4'b1101, 1, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 3, 4'b1111, 1, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 3, 4'b1011, 2, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1011, 2, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1011, 2, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1111, 2, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1110, 0, 1));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1110, 0, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1110, 0, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1111, 0, 0));
    for (int d = 0; d < 3; d++) vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1101, 1, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1111, 1, 0));
    vt.push_back(mk(4, 0, 0, 1, 0, 1, 4'b1110, 0, 1));
    for (int f = 0; f < 2; f++) begin
      vt.push_back(mk(4, 0, 0, 1, 0, 0, 4'b1110, 0, 0));
      vt.push_back(mk(4, 0, 0, 1, 0, 0, 4'b1110, 0, 0));
      vt.push_back(mk(4, 0, 0, 1, 0, 0, 4'b1111, 0, 0));
      vt.push_back(mk(4, 0, 0, 1, 0, 0, 4'b1110, 0, 1));
    end
    // 5. instance B: no gap, one-cycle dwell; G_L high on a wrapping advance
    vt.push_back(mk(5, 1, 0, 0, 0, 3, 4'b1110, 0, 0));
    for (int k = 0; k < 8; k++) begin
      oh = 4'b1111;
      oh[k % 4] = 1'b0;
      vt.push_back(mk(5, 1, 0, 1, 0, 3, oh, 2'(k % 4), (k == 4) ? 1'b1 : 1'b0));
    end
    vt.push_back(mk(5, 1, 1, 1, 0, 3, 4'b1111, 3, 0));
    // 6. mid-dwell disable, re-entry
    vt.push_back(mk(6, 0, 0, 0, 3, 3, 4'b0111, 3, 0));
    for (int d = 0; d < 3; d++) vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1110, 0, 0));
    vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1111, 0, 0));
    vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1101, 1, 0));
    vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1101, 1, 0));
    vt.push_back(mk(6, 0, 1, 1, 0, 3, 4'b1111, 1, 0));
    for (int d = 0; d < 3; d++) vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1110, 0, 0));
    vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1111, 0, 0));
    vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1101, 1, 0));
    run_table();

    // Reset pulse mid-dwell: outputs clear without waiting for an edge.
    RESET_L = 1'b0;
    #1;
    check("reset_mid_scan", {y_a, idx_a, wrap_a}, {4'b1111, 2'd0, 1'b0});
    #1;
    RESET_L = 1'b1;
    vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1110, 0, 0));
    vt.push_back(mk(6, 0, 0, 1, 0, 3, 4'b1110, 0, 0));
    vt.push_back(mk(6, 0, 0, 0, 1, 3, 4'b1101, 1, 0));
    vt.push_back(mk(6, 0, 0, 1, 1, 3, 4'b1110, 0, 0));
    vt.push_back(mk(6, 0, 0, 1, 1, 3, 4'b1110, 0, 0));
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
